scan_sequencer: RTL
===================

# scan_sequencer

Sequential address generator that sits directly upstream of the 2-to-4 line decoder. It drives the decoder's 2-bit select input, stepping through the four output lines in ascending order. Each line is held for a programmable dwell time, and lines can be skipped with a mask. The block supports continuous scanning (display/keypad multiplexing) and single-sweep scanning with a start/done handshake.

## Interface
- `DWELL_W`, default 8: width of the dwell count; each address is held `dwell+1` cycles.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `en`, input, 1: run enable; low pauses an active scan.
- `start`, input, 1: single-cycle request to begin a scan; sampled only in IDLE.
- `mode`, input, 1: 0 = continuous, 1 = single sweep; sampled with `start`.
- `dwell`, input, `DWELL_W`: hold count; sampled each time a new address is loaded.
- `mask`, input, 4: bit i = 1 enables line i; read live every cycle.
- `addr`, output, 2: select to the decoder's `A` input.
- `addr_vld`, output, 1: `addr` is meaningful; gates the decoder outputs downstream.
- `step`, output, 1: one-cycle pulse when `addr` advances (not on the initial load).
- `wrap`, output, 1: one-cycle pulse when `addr` returns to the lowest enabled index (continuous mode).
- `busy`, output, 1: high while in SCAN.
- `done`, output, 1: one-cycle pulse at the end of a single sweep.

## Operation
- **Reset values:** state = IDLE; `addr`=0; `addr_vld`=0; `step`=0; `wrap`=0; `busy`=0; `done`=0; dwell counter = 0. Reset overrides everything, including mid-scan.
- **FSM states:** IDLE, SCAN, DONE. All outputs are registered.
- **IDLE → SCAN:** when `start && en && mask!=0`.
  - Load `addr` with the lowest set bit index of `mask` and the counter with `dwell`.
  - Latch `mode`; set `addr_vld`=1 and `busy`=1.
  - `start` with `mask==0` or `en==0` is dropped, with no response.
- **SCAN, `en`=0:** counter and `addr` freeze; `addr_vld` stays 1; `step`/`wrap` stay 0.
- **SCAN, `en`=1, counter≠0:** counter decrements by 1.
- **SCAN, `en`=1, counter==0:** compute the next enabled index strictly above `addr` under the current `mask`.
  - If one exists: load it and `dwell`, pulse `step`.
  - If none exists (wrap), continuous mode: load the lowest enabled index and `dwell`, pulse `step` and `wrap`.
  - If none exists (wrap), single mode: go to DONE with `addr_vld`=0, `busy`=0, `done`=1.
  - A single enabled line in continuous mode reloads the same `addr` and pulses `step` and `wrap` every `dwell+1` cycles.
- **SCAN, `mask` becomes 0 (checked before the counter):** abort to IDLE the next cycle. `addr_vld`=0, `busy`=0, no `done`. `addr` keeps its last value.
- **Mask change mid-dwell:** the current address finishes its dwell even if its bit has been cleared; the new mask applies at the next advance.
- **DONE:** lasts exactly one cycle, then IDLE; `done` falls. `start` in DONE is ignored.
- **Arithmetic:** the dwell counter is unsigned `DWELL_W` bits and never underflows. `dwell=0` gives a one-cycle hold per address.

## Timing
- **Start latency:** `start` sampled at cycle N gives `addr`/`addr_vld`/`busy` valid at N+1.
- **Hold time:** each address is held exactly `dwell+1` enabled cycles. Paused cycles do not count.
- **Pulse alignment:** `step`/`wrap` are high in the first cycle the new `addr` is presented. `done` is high in the cycle after the final address's last dwell cycle, and `addr_vld` is 0 in that same cycle.
- **Handshake:** `start` is level-ignored outside IDLE; there is no queuing.

## Structure
- **Package `scan_pkg`:** state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2) and the mode constants `MODE_CONT`=1'b0 and `MODE_SINGLE`=1'b1. It is shared with the bench.
- **Sub-module `scan_next_sel`:** combinational; inputs `addr[1:0]` and `mask[3:0]`; outputs `next_idx[1:0]`, `first_idx[1:0]`, `has_next`. It is reused for the IDLE load (`first_idx`) and the SCAN advance.

## Test plan
- **Single sweep:** `mode`=1, `mask`=4'b1011, `dwell`=2, `start` at cycle 0 → `addr`=0 during cycles 1-3, 1 during 4-6, 3 during 7-9. `step` at cycles 4 and 7. Cycle 10: `done`=1, `addr_vld`=0, `busy`=0. Cycle 11: IDLE.
- **Continuous, full mask:** `mode`=0, `mask`=4'b1111, `dwell`=0 → `addr` sequence 0,1,2,3,0,… one per cycle; `wrap` each time `addr` returns to 0; `done` never asserts.
- **Pause:** `en` low for 5 cycles in the middle of an address's dwell → `addr` is held 5 cycles longer than `dwell+1`; no `step` during the pause.
- **Abort:** `mask` driven to 0 during SCAN → IDLE next cycle, `addr_vld`=0, no `done`. A later `start` with `mask`=4'b0100 loads `addr`=2.
- **Dropped start and reset:** `start` with `mask`=0 → no response. `start` during SCAN → ignored. `rst_n` low mid-scan → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: FSM encoding and sweep-mode constants.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between the scan sequencer and its host.
// Master drives the scan controls; slave (the sequencer) drives the decoder select and status.
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic               start;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         mask;
    logic [1:0]         addr;
    logic               addr_vld;
    logic               step;
    logic               wrap;
    logic               busy;
    logic               done;

    modport master (
        output en, start, mode, dwell, mask,
        input  addr, addr_vld, step, wrap, busy, done
    );

    modport slave (
        input  en, start, mode, dwell, mask,
        output addr, addr_vld, step, wrap, busy, done
    );
endinterface

// File: rtl/scan_sequencer_next_sel.sv
// Picks the lowest enabled line and the next enabled line strictly above the current address.
module scan_next_sel (
    input  logic [1:0] addr,
    input  logic [3:0] mask,
    output logic [1:0] next_idx,
    output logic [1:0] first_idx,
    output logic       has_next
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        first_idx = 2'd0;
        next_idx  = 2'd0;
        has_next  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = i[1:0];
                if (i > int'(addr)) begin
                    next_idx = i[1:0];
                    has_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Address generator feeding the 2-to-4 decoder: steps through enabled lines with a
// programmable dwell, in continuous or single-sweep mode.
//
// state | meaning
// IDLE  | waiting for start; addr_vld low
// SCAN  | presenting addr, counting down the dwell
// DONE  | one-cycle done pulse after a single sweep
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);

    scan_state_t        state_q, state_d;
    logic [1:0]         addr_q, addr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               vld_q, vld_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [1:0]         next_idx;
    logic [1:0]         first_idx;
    logic               has_next;
    logic               start_ok;
    logic               mask_zero;
    logic               cnt_zero;

    scan_next_sel u_next_sel (
        .addr      (addr_q),
        .mask      (bus.mask),
        .next_idx  (next_idx),
        .first_idx (first_idx),
        .has_next  (has_next)
    );

    assign mask_zero = (bus.mask == 4'd0);
    assign start_ok  = bus.start && bus.en && !mask_zero;
    assign cnt_zero  = (cnt_q == '0);

    // State and registered outputs; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 2'd0;
            cnt_q   <= '0;
            mode_q  <= MODE_CONT;
            vld_q   <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; an emptied mask aborts before the dwell counter is consulted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = SCAN;
            SCAN: begin
                if (mask_zero) begin
                    state_d = IDLE;
                end else if (bus.en && cnt_zero && !has_next && mode_q == MODE_SINGLE) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; step/wrap/done are single-cycle pulses.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        vld_d  = vld_q;
        busy_d = busy_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    addr_d = first_idx;
                    cnt_d  = bus.dwell;
                    mode_d = bus.mode;
                    vld_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            SCAN: begin
                if (mask_zero) begin
                    vld_d  = 1'b0;
                    busy_d = 1'b0;
                end else if (bus.en) begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                    end else if (has_next) begin
                        addr_d = next_idx;
                        cnt_d  = bus.dwell;
                        step_d = 1'b1;
                    end else if (mode_q == MODE_CONT) begin
                        addr_d = first_idx;
                        cnt_d  = bus.dwell;
                        step_d = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        vld_d  = 1'b0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                vld_d  = 1'b0;
                busy_d = 1'b0;
            end
            default: begin
                vld_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.addr     = addr_q;
    assign bus.addr_vld = vld_q;
    assign bus.step     = step_q;
    assign bus.wrap     = wrap_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
